mem_access_unit: RTL and testbench

Parametrised load/store unit for the MEM pipeline stage: sits between the EX/MEM and MEM/WB pipeline registers, owns the data memory, and replaces the word-only `dataMem` path with byte/half/word (and doubleword at XLEN=64) accesses. Lane steering on stores, sign/zero extension on loads and misalignment detection are performed inside the block. The memory read latency is configurable. A stall/valid/ready handshake holds the pipeline while an access is in flight.

---
 rtl/mem_access_unit_pkg.sv | 29 ++
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit_data_mem_bank.sv | 21 ++
 rtl/mem_access_unit.sv | 103 ++++++++++
 tb/tb_mem_access_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage load/store unit: access size codes, FSM
// states and the alignment rule.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Doubleword accesses only exist on a 64-bit datapath.
  function automatic logic isMisaligned(input logic [1:0] sz, input logic [2:0] lo,
                                        input int unsigned xlen);
    case (size_e'(sz))
      SZ_H:    return lo[0];
      SZ_W:    return |lo[1:0];
      SZ_D:    return (xlen == 32) || (|lo);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side bundle of the load/store unit: request from EX/MEM,
// result and stall back towards the pipeline.
interface mem_access_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            mem_read;
  logic            mem_write;
  logic [1:0]      size;
  logic            load_unsigned;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            out_ready;
  logic            stall;
  logic            out_valid;
  logic [XLEN-1:0] rdata;
  logic            misaligned;

  modport master (
    output in_valid, mem_read, mem_write, size, load_unsigned, addr, wdata, out_ready,
    input  stall, out_valid, rdata, misaligned
  );

  modport slave (
    input  in_valid, mem_read, mem_write, size, load_unsigned, addr, wdata, out_ready,
    output stall, out_valid, rdata, misaligned
  );
endinterface

// File: rtl/mem_access_unit_data_mem_bank.sv
// Data memory: synchronous single-port RAM with per-byte write enables and a
// registered read port. Contents are not touched by reset.
module data_mem_bank #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [XLEN/8-1:0]        byte_en,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);
  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < XLEN / 8; b++) begin
      if (byte_en[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte/half/word/dword accesses with lane steering,
// load extension, alignment checking and a latency-configurable memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);
  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned OFS = $clog2(NB);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = $clog2(XLEN);
  localparam int unsigned CW  = ($clog2(LATENCY) < 2) ? 2 : $clog2(LATENCY);

  state_e          state, stateNext;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   idxQ;
  logic [OFS-1:0]  ofsQ;
  logic [1:0]      sizeQ;
  logic            writeQ, unsQ;
  logic [XLEN-1:0] wdataQ, rdataQ;
  logic            memop, accept, commit;
  logic [AW-1:0]   ramAddr;
  logic [NB-1:0]   sizeMask, byteEn;
  logic [XLEN-1:0] ramWdata, ramRdata, lane, keep, loadVal;
  logic [LW-1:0]   msb;

  assign memop          = bus.in_valid & (bus.mem_read | bus.mem_write);
  assign bus.misaligned = memop & isMisaligned(bus.size, bus.addr[2:0], XLEN)
                          & (state == IDLE) & !rst;
  assign accept         = memop & !bus.misaligned & (state == IDLE) & !rst;
  assign commit         = (state == BUSY) && (cnt == '0) && !rst;
  assign bus.stall      = !rst & memop & !bus.misaligned & !((state == DONE) & bus.out_ready);
  assign bus.out_valid  = (state == DONE);
  assign bus.rdata      = rdataQ;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = BUSY;
      BUSY:    if (cnt == '0) stateNext = DONE;
      DONE:    if (bus.out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rdataQ <= '0;
    end else begin
      state <= stateNext;
      if (accept) cnt <= CW'(LATENCY - 1);
      else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
      if (commit) rdataQ <= writeQ ? '0 : loadVal;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idxQ   <= bus.addr[OFS+AW-1:OFS];
      ofsQ   <= bus.addr[OFS-1:0];
      sizeQ  <= bus.size;
      writeQ <= bus.mem_write;
      unsQ   <= bus.load_unsigned;
      wdataQ <= bus.wdata;
    end
  end

  // The RAM sees the live address while idle so its registered read is
  // already valid by the commit edge, even at LATENCY=1.
  assign ramAddr  = (state == IDLE) ? bus.addr[OFS+AW-1:OFS] : idxQ;
  assign sizeMask = NB'((1 << (1 << sizeQ)) - 1);
  assign byteEn   = (commit && writeQ) ? (sizeMask << ofsQ) : '0;
  assign ramWdata = wdataQ << {ofsQ, 3'b000};

  always_comb begin
    int unsigned fieldBits;
    fieldBits = 8 << sizeQ;
    if (fieldBits > XLEN) fieldBits = XLEN;
    lane    = ramRdata >> {ofsQ, 3'b000};
    keep    = '1 >> (XLEN - fieldBits);
    msb     = LW'(fieldBits - 1);
    loadVal = (lane & keep) | ({XLEN{!unsQ && lane[msb]}} & ~keep);
  end

  data_mem_bank #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) bank (
    .clk    (clk),
    .addr   (ramAddr),
    .byte_en(byteEn),
    .wdata  (ramWdata),
    .rdata  (ramRdata)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: three unit configurations driven from one directed and
// randomized sequence, checked against a byte-array memory model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        inValid, memRead, memWrite, loadUns, outReady;
  logic [1:0]  size;
  logic [63:0] reqAddr, reqWdata;
  logic        obsStall, obsValid, obsMis;
  logic [63:0] obsRdata;
  int          nCmp = 0;
  int          nErr = 0;

  int unsigned latOf[3] = '{1, 3, 1};
  int unsigned xlOf[3]  = '{32, 32, 64};
  int unsigned mbOf[3]  = '{4096, 256, 128};
  logic [7:0]  refMem[3][4096];

  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(32)) ifA ();
  mem_access_unit_if #(.XLEN(32)) ifB ();
  mem_access_unit_if #(.XLEN(64)) ifC ();

  assign ifA.in_valid = inValid && (sel == 2'd0);
  assign ifA.mem_read = memRead;
  assign ifA.mem_write = memWrite;
  assign ifA.size = size;
  assign ifA.load_unsigned = loadUns;
  assign ifA.addr = reqAddr[31:0];
  assign ifA.wdata = reqWdata[31:0];
  assign ifA.out_ready = outReady;

  assign ifB.in_valid = inValid && (sel == 2'd1);
  assign ifB.mem_read = memRead;
  assign ifB.mem_write = memWrite;
  assign ifB.size = size;
  assign ifB.load_unsigned = loadUns;
  assign ifB.addr = reqAddr[31:0];
  assign ifB.wdata = reqWdata[31:0];
  assign ifB.out_ready = outReady;

  assign ifC.in_valid = inValid && (sel == 2'd2);
  assign ifC.mem_read = memRead;
  assign ifC.mem_write = memWrite;
  assign ifC.size = size;
  assign ifC.load_unsigned = loadUns;
  assign ifC.addr = reqAddr;
  assign ifC.wdata = reqWdata;
  assign ifC.out_ready = outReady;

  mem_access_unit #(.XLEN(32), .DEPTH(1024), .LATENCY(1)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  mem_access_unit #(.XLEN(32), .DEPTH(64),   .LATENCY(3)) dutB (.clk(clk), .rst(rst), .bus(ifB));
  mem_access_unit #(.XLEN(64), .DEPTH(16),   .LATENCY(1)) dutC (.clk(clk), .rst(rst), .bus(ifC));

  always_comb begin
    obsStall = ifA.stall;
    obsValid = ifA.out_valid;
    obsMis   = ifA.misaligned;
    obsRdata = {32'd0, ifA.rdata};
    if (sel == 2'd1) begin
      obsStall = ifB.stall;
      obsValid = ifB.out_valid;
      obsMis   = ifB.misaligned;
      obsRdata = {32'd0, ifB.rdata};
    end else if (sel == 2'd2) begin
      obsStall = ifC.stall;
      obsValid = ifC.out_valid;
      obsMis   = ifC.misaligned;
      obsRdata = ifC.rdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic expMisaligned(int d, logic [1:0] sz, logic [63:0] a);
    case (sz)
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'd0;
      2'd3:    return (xlOf[d] == 32) || (a[2:0] != 3'd0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] modelLoad(int d, logic [1:0] sz, logic uns, logic [63:0] a);
    int unsigned n, base;
    logic [63:0] v;
    n    = 1 << sz;
    base = 32'(a % 64'(mbOf[d]));
    v    = '0;
    for (int k = 0; k < int'(n); k++) v = v | (64'(refMem[d][base + k]) << (8 * k));
    if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    if (xlOf[d] == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic modelStore(int d, logic [1:0] sz, logic [63:0] a, logic [63:0] wd);
    int unsigned n, base;
    n    = 1 << sz;
    base = 32'(a % 64'(mbOf[d]));
    for (int k = 0; k < int'(n); k++) refMem[d][base + k] = wd[8*k +: 8];
  endtask

  task automatic doAccess(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [63:0] a, input logic [63:0] wd,
                          input int readyDelay, output logic [63:0] got);
    logic        mis;
    logic [63:0] exp;
    @(negedge clk);
    sel = 2'(d); inValid = 1'b1; memRead = rd; memWrite = wr; size = sz;
    loadUns = uns; reqAddr = a; reqWdata = wd; outReady = (readyDelay == 0);
    #1;
    mis = expMisaligned(d, sz, a);
    check("misaligned", obsMis, mis);
    got = '0;
    if (mis) begin
      check("stallOnMisalign", obsStall, 0);
      @(posedge clk); #1;
      check("misalignNoAccept", obsMis, 1);
      check("misalignNoStall", obsStall, 0);
      inValid = 1'b0;
      return;
    end
    check("stallAtAccept", obsStall, 1);
    if (wr) begin
      exp = '0;
      modelStore(d, sz, a, wd);
    end else begin
      exp = modelLoad(d, sz, uns, a);
    end
    @(posedge clk); #1;
    // accepted: scramble everything except the request itself
    reqAddr = {$urandom, $urandom}; reqWdata = {$urandom, $urandom};
    size = 2'($urandom_range(0, 2)); loadUns = 1'($urandom);
    for (int n = 1; n <= int'(latOf[d]); n++) begin
      @(negedge clk);
      check("busyValid", obsValid, 0);
      check("busyStall", obsStall, 1);
    end
    @(negedge clk);
    check("doneValid", obsValid, 1);
    check("doneRdata", obsRdata, exp);
    check("doneStall", obsStall, readyDelay != 0);
    got = obsRdata;
    for (int r = 0; r < readyDelay; r++) begin
      @(negedge clk);
      check("holdValid", obsValid, 1);
      check("holdRdata", obsRdata, exp);
      check("holdStall", obsStall, 1);
    end
    outReady = 1'b1;
    #1;
    check("releaseStall", obsStall, 0);
    @(posedge clk); #1;
    inValid = 1'b0;
    check("backToIdle", obsValid, 0);
  endtask

  task automatic resetDuringStore(input int d, input int busyCycle, input logic [63:0] a);
    @(negedge clk);
    sel = 2'(d); inValid = 1'b1; memRead = 1'b0; memWrite = 1'b1; size = 2'd2;
    reqAddr = a; reqWdata = 64'hDEAD_BEEF; outReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    for (int i = 1; i < busyCycle; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abortNoValid", obsValid, 0);
      check("abortNoStall", obsStall, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] got, a;
    logic [1:0]  sz;
    int          op;
    int unsigned region;

    rst = 1'b1; sel = 2'd0; inValid = 1'b1; memRead = 1'b1; memWrite = 1'b0;
    size = 2'd1; loadUns = 1'b0; reqAddr = 64'h1; reqWdata = '0; outReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstMisaligned", obsMis, 0);
    check("rstStall", obsStall, 0);
    check("rstValid", obsValid, 0);
    check("rstRdata", obsRdata, 0);
    inValid = 1'b0;
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) begin
        if (d == 2) doAccess(d, 0, 1, 2'd3, 0, 64'(w * 8), {$urandom, $urandom}, 0, got);
        else        doAccess(d, 0, 1, 2'd2, 0, 64'(w * 4), 64'($urandom), 0, got);
      end
    end

    doAccess(0, 0, 1, 2'd2, 0, 64'h10, 64'h1122_3344, 0, got);
    doAccess(0, 0, 1, 2'd0, 0, 64'h11, 64'h1234_56AA, 0, got);
    doAccess(0, 1, 0, 2'd2, 0, 64'h10, '0, 0, got);
    check("LW@10", got, 64'h1122_AA44);
    doAccess(0, 1, 0, 2'd0, 0, 64'h11, '0, 0, got);
    check("LB@11", got, 64'hFFFF_FFAA);
    doAccess(0, 1, 0, 2'd0, 1, 64'h11, '0, 1, got);
    check("LBU@11", got, 64'h0000_00AA);
    doAccess(0, 1, 0, 2'd1, 0, 64'h12, '0, 0, got);
    check("LH@12", got, 64'h0000_1122);
    doAccess(0, 1, 0, 2'd1, 0, 64'h13, '0, 0, got);
    doAccess(0, 1, 0, 2'd2, 0, 64'h10, '0, 0, got);
    check("LWafterMisalign", got, 64'h1122_AA44);
    doAccess(0, 1, 0, 2'd3, 0, 64'h18, '0, 0, got);
    doAccess(0, 1, 1, 2'd2, 0, 64'h0, 64'h5, 0, got);
    check("writeWinsRdata", got, 64'h0);
    doAccess(0, 1, 0, 2'd2, 0, 64'h0, '0, 0, got);
    check("writeWinsStored", got, 64'h5);

    doAccess(1, 1, 0, 2'd2, 0, 64'h20, '0, 5, got);
    resetDuringStore(1, 2, 64'h20);
    doAccess(1, 1, 0, 2'd2, 0, 64'h20, '0, 0, got);
    resetDuringStore(0, 1, 64'h24);
    doAccess(0, 1, 0, 2'd2, 0, 64'h24, '0, 0, got);

    doAccess(2, 0, 1, 2'd3, 0, 64'h80, 64'h0123_4567_89AB_CDEF, 0, got);
    doAccess(2, 1, 0, 2'd3, 0, 64'h00, '0, 0, got);
    check("LDalias", got, 64'h0123_4567_89AB_CDEF);
    doAccess(2, 1, 0, 2'd2, 0, 64'h04, '0, 0, got);
    check("LW@04", got, 64'h0000_0000_0123_4567);
    doAccess(2, 1, 0, 2'd2, 0, 64'h00, '0, 1, got);
    check("LW@00sext", got, 64'hFFFF_FFFF_89AB_CDEF);

    for (int d = 0; d < 3; d++) begin
      region = (d == 2) ? 128 : 64;
      for (int i = 0; i < 40; i++) begin
        op = int'($urandom_range(0, 2));
        sz = 2'($urandom_range(0, 3));
        a  = 64'($urandom_range(0, region - 1));
        if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
        a = ({$urandom, $urandom} & ~64'(mbOf[d] - 1)) | a;
        doAccess(d, op != 1, op != 0, sz, 1'($urandom), a, {$urandom, $urandom},
                 int'($urandom_range(0, 2)), got);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
